kv_store_block: RTL and testbench



---
 rtl/kv_store_pkg.sv | 28 ++
 rtl/kv_entry.sv | 52 +++++
 rtl/kv_store_block.sv | 194 +++++++++++++++++++
 tb/tb_kv_store_block.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/kv_store_pkg.sv
// rtl/kv_store_pkg.sv - shared opcode, status and FSM state types for the key/value store
package kv_store_pkg;

    typedef enum logic [1:0] {
        OP_GET   = 2'd0,
        OP_PUT   = 2'd1,
        OP_DEL   = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_HIT      = 3'd0,
        ST_MISS     = 3'd1,
        ST_INSERTED = 3'd2,
        ST_UPDATED  = 3'd3,
        ST_EVICTED  = 3'd4,
        ST_DELETED  = 3'd5,
        ST_FULL     = 3'd6,
        ST_CLEARED  = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/kv_entry.sv
// rtl/kv_entry.sv - one key/value slot with its LRU rank and key comparator
module kv_entry #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int AGE_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_WIDTH-1:0]   lookup_key,
    input  logic                   wr_en,
    input  logic [KEY_WIDTH-1:0]   wr_key,
    input  logic [VALUE_WIDTH-1:0] wr_value,
    input  logic                   touch,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   inv,
    input  logic                   clr,
    output logic                   valid,
    output logic [VALUE_WIDTH-1:0] value,
    output logic [AGE_W-1:0]       age,
    output logic                   match
);

    logic [KEY_WIDTH-1:0] key_q;

    // Strobes are mutually exclusive by construction; the priority only documents intent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            key_q <= '0;
            value <= '0;
            age   <= '0;
        end else if (clr || inv) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            key_q <= wr_key;
            value <= wr_value;
            age   <= '0;
        end else if (touch) begin
            age <= '0;
        end else if (inc) begin
            age <= age + AGE_W'(1);
        end else if (dec) begin
            age <= age - AGE_W'(1);
        end
    end

    assign match = valid && (key_q == lookup_key);

endmodule

// File: rtl/kv_store_block.sv
// rtl/kv_store_block.sv - fully-associative key/value store with LRU eviction and occupancy tracking
module kv_store_block
    import kv_store_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int EVICT_EN    = 1,
    parameter int AGE_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_op,
    input  logic [KEY_WIDTH-1:0]               req_key,
    input  logic [VALUE_WIDTH-1:0]             req_value,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [2:0]                         resp_status,
    output logic [VALUE_WIDTH-1:0]             resp_value,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
    output logic                               full
);

    localparam int OCC_W = $clog2(NUM_ENTRIES+1);
    localparam logic [AGE_W-1:0] MAX_AGE  = AGE_W'(NUM_ENTRIES-1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(NUM_ENTRIES);

    state_e                 state;
    op_e                    op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;

    logic [NUM_ENTRIES-1:0] valid_vec, match_vec;
    logic [VALUE_WIDTH-1:0] value_arr [NUM_ENTRIES];
    logic [AGE_W-1:0]       age_arr   [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] wr_vec, touch_vec, inc_vec, dec_vec, inv_vec;
    logic                   clr_all, lookup;
    logic                   hit;
    logic [AGE_W-1:0]       hit_idx, free_idx, victim_idx, hit_age;
    status_e                status_next;
    logic [VALUE_WIDTH-1:0] rv_next;
    logic [OCC_W-1:0]       occ_next;

    assign lookup = (state == S_LOOKUP);

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        kv_entry #(
            .KEY_WIDTH   (KEY_WIDTH),
            .VALUE_WIDTH (VALUE_WIDTH),
            .AGE_W       (AGE_W)
        ) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .lookup_key (key_q),
            .wr_en      (wr_vec[g] & lookup),
            .wr_key     (key_q),
            .wr_value   (value_q),
            .touch      (touch_vec[g] & lookup),
            .inc        (inc_vec[g] & lookup),
            .dec        (dec_vec[g] & lookup),
            .inv        (inv_vec[g] & lookup),
            .clr        (clr_all & lookup),
            .valid      (valid_vec[g]),
            .value      (value_arr[g]),
            .age        (age_arr[g]),
            .match      (match_vec[g])
        );
    end

    // Hit index, lowest free slot and LRU victim (the only valid entry holding the max rank).
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        victim_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (match_vec[i]) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
            if (valid_vec[i] && age_arr[i] == MAX_AGE) victim_idx = AGE_W'(i);
        end
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = AGE_W'(i);
        end
        hit_age = age_arr[hit_idx];
    end

    always_comb begin
        wr_vec      = '0;
        touch_vec   = '0;
        inc_vec     = '0;
        dec_vec     = '0;
        inv_vec     = '0;
        clr_all     = 1'b0;
        status_next = ST_MISS;
        rv_next     = '0;
        occ_next    = occupancy;
        case (op_q)
            OP_GET: begin
                if (hit) begin
                    status_next        = ST_HIT;
                    rv_next            = value_arr[hit_idx];
                    touch_vec[hit_idx] = 1'b1;
                    for (int i = 0; i < NUM_ENTRIES; i++)
                        inc_vec[i] = valid_vec[i] && (age_arr[i] < hit_age);
                end
            end
            OP_PUT: begin
                if (hit) begin
                    status_next     = ST_UPDATED;
                    wr_vec[hit_idx] = 1'b1;
                    for (int i = 0; i < NUM_ENTRIES; i++)
                        inc_vec[i] = valid_vec[i] && (age_arr[i] < hit_age);
                end else if (!full) begin
                    status_next      = ST_INSERTED;
                    wr_vec[free_idx] = 1'b1;
                    inc_vec          = valid_vec;
                    occ_next         = occupancy + OCC_W'(1);
                end else if (EVICT_EN != 0) begin
                    status_next        = ST_EVICTED;
                    rv_next            = value_arr[victim_idx];
                    wr_vec[victim_idx] = 1'b1;
                    for (int i = 0; i < NUM_ENTRIES; i++)
                        inc_vec[i] = valid_vec[i] && (age_arr[i] != MAX_AGE);
                end else begin
                    status_next = ST_FULL;
                end
            end
            OP_DEL: begin
                if (hit) begin
                    status_next      = ST_DELETED;
                    inv_vec[hit_idx] = 1'b1;
                    occ_next         = occupancy - OCC_W'(1);
                    for (int i = 0; i < NUM_ENTRIES; i++)
                        dec_vec[i] = valid_vec[i] && (age_arr[i] > hit_age);
                end
            end
            OP_CLEAR: begin
                status_next = ST_CLEARED;
                clr_all     = 1'b1;
                occ_next    = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= OP_GET;
            key_q       <= '0;
            value_q     <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_status <= 3'd0;
            resp_value  <= '0;
            occupancy   <= '0;
            full        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_e'(req_op);
                        key_q     <= req_key;
                        value_q   <= req_value;
                        req_ready <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    resp_status <= status_next;
                    resp_value  <= rv_next;
                    occupancy   <= occ_next;
                    full        <= (occ_next == OCC_FULL);
                    resp_valid  <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kv_store_block.sv
// tb/tb_kv_store_block.sv - directed vector bench for kv_store_block (evicting and non-evicting instances)
module tb_kv_store_block;

    localparam int N = 4;
    localparam logic [1:0] GET = 2'd0, PUT = 2'd1, DEL = 2'd2, CLR = 2'd3;
    localparam logic [2:0] HIT = 3'd0, MISS = 3'd1, INS = 3'd2, UPD = 3'd3,
                           EVI = 3'd4, DLT = 3'd5, FUL = 3'd6, CLRD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [15:0] req_key = '0;
    logic [63:0] req_value = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready_a, resp_valid_a, full_a;
    logic [2:0]  resp_status_a, occ_a;
    logic [63:0] resp_value_a;
    logic        req_ready_b, resp_valid_b, full_b;
    logic [2:0]  resp_status_b, occ_b;
    logic [63:0] resp_value_b;

    always #5 clk = ~clk;

    kv_store_block #(.NUM_ENTRIES(N), .KEY_WIDTH(16), .VALUE_WIDTH(64), .EVICT_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_status(resp_status_a),
        .resp_value(resp_value_a), .occupancy(occ_a), .full(full_a)
    );

    kv_store_block #(.NUM_ENTRIES(N), .KEY_WIDTH(16), .VALUE_WIDTH(64), .EVICT_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_op(req_op), .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_status(resp_status_b),
        .resp_value(resp_value_b), .occupancy(occ_b), .full(full_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] key;
        logic [63:0] val;
        logic [2:0]  st_a;
        logic [63:0] rv_a;
        logic [2:0]  st_b;
        logic [63:0] rv_b;
        logic [2:0]  occ;
        logic        full;
    } vec_t;

    vec_t vecs[$];
    int applied = 0;
    int miscompares = 0;
    logic [2:0]  cap_st_a, cap_st_b;
    logic [63:0] cap_rv_a, cap_rv_b;
    int          lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val,
                                input logic [2:0] st_a, input logic [63:0] rv_a,
                                input logic [2:0] st_b, input logic [63:0] rv_b,
                                input logic [2:0] occ, input logic fl);
        vec_t v;
        v.op = op; v.key = key; v.val = val;
        v.st_a = st_a; v.rv_a = rv_a; v.st_b = st_b; v.rv_b = rv_b;
        v.occ = occ; v.full = fl;
        vecs.push_back(v);
    endfunction

    // Called at posedge+1; returns at posedge+1 with the response consumed.
    task automatic run_req(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val);
        int n;
        check("req_ready_idle", req_ready_a, 1'b1);
        req_valid = 1'b1; req_op = op; req_key = key; req_value = val; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid_a && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n + 1;
        check("resp_valid_seen", resp_valid_a, 1'b1);
        cap_st_a = resp_status_a; cap_rv_a = resp_value_a;
        cap_st_b = resp_status_b; cap_rv_b = resp_value_b;
        @(posedge clk); #1;
        check("resp_valid_drop", resp_valid_a, 1'b0);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            run_req(vecs[i].op, vecs[i].key, vecs[i].val);
            check($sformatf("v%0d_status_a", i), cap_st_a, vecs[i].st_a);
            check($sformatf("v%0d_value_a", i),  cap_rv_a, vecs[i].rv_a);
            check($sformatf("v%0d_status_b", i), cap_st_b, vecs[i].st_b);
            check($sformatf("v%0d_value_b", i),  cap_rv_b, vecs[i].rv_b);
            check($sformatf("v%0d_occ_a", i),    occ_a,    vecs[i].occ);
            check($sformatf("v%0d_occ_b", i),    occ_b,    vecs[i].occ);
            check($sformatf("v%0d_full_a", i),   full_a,   vecs[i].full);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // 0-4: miss on empty, insert/update/hit
        add(GET, 16'h1, 64'h0,  MISS, 64'h0,  MISS, 64'h0,  3'd0, 1'b0);
        add(PUT, 16'h1, 64'hAA, INS,  64'h0,  INS,  64'h0,  3'd1, 1'b0);
        add(PUT, 16'h1, 64'hBB, UPD,  64'h0,  UPD,  64'h0,  3'd1, 1'b0);
        add(GET, 16'h1, 64'h0,  HIT,  64'hBB, HIT,  64'hBB, 3'd1, 1'b0);
        add(CLR, 16'h0, 64'h0,  CLRD, 64'h0,  CLRD, 64'h0,  3'd0, 1'b0);
        // 5-16: fill, LRU eviction vs FULL rejection
        add(PUT, 16'h1, 64'h10, INS,  64'h0,  INS,  64'h0,  3'd1, 1'b0);
        add(PUT, 16'h2, 64'h20, INS,  64'h0,  INS,  64'h0,  3'd2, 1'b0);
        add(PUT, 16'h3, 64'h30, INS,  64'h0,  INS,  64'h0,  3'd3, 1'b0);
        add(PUT, 16'h4, 64'h40, INS,  64'h0,  INS,  64'h0,  3'd4, 1'b1);
        add(GET, 16'h1, 64'h0,  HIT,  64'h10, HIT,  64'h10, 3'd4, 1'b1);
        add(PUT, 16'h5, 64'h50, EVI,  64'h20, FUL,  64'h0,  3'd4, 1'b1);
        add(GET, 16'h2, 64'h0,  MISS, 64'h0,  HIT,  64'h20, 3'd4, 1'b1);
        add(GET, 16'h1, 64'h0,  HIT,  64'h10, HIT,  64'h10, 3'd4, 1'b1);
        add(PUT, 16'h9, 64'h99, EVI,  64'h30, FUL,  64'h0,  3'd4, 1'b1);
        add(GET, 16'h9, 64'h0,  HIT,  64'h99, MISS, 64'h0,  3'd4, 1'b1);
        add(CLR, 16'h0, 64'h0,  CLRD, 64'h0,  CLRD, 64'h0,  3'd0, 1'b0);
        // 16-22: delete and re-insert into the freed slot
        add(PUT, 16'h1, 64'h11, INS,  64'h0,  INS,  64'h0,  3'd1, 1'b0);
        add(PUT, 16'h2, 64'h22, INS,  64'h0,  INS,  64'h0,  3'd2, 1'b0);
        add(PUT, 16'h3, 64'h33, INS,  64'h0,  INS,  64'h0,  3'd3, 1'b0);
        add(DEL, 16'h2, 64'h0,  DLT,  64'h0,  DLT,  64'h0,  3'd2, 1'b0);
        add(DEL, 16'h2, 64'h0,  MISS, 64'h0,  MISS, 64'h0,  3'd2, 1'b0);
        add(PUT, 16'h7, 64'h77, INS,  64'h0,  INS,  64'h0,  3'd3, 1'b0);
        // 22-28: ranks after delete must make key 1 the LRU
        add(GET, 16'h3, 64'h0,  HIT,  64'h33, HIT,  64'h33, 3'd3, 1'b0);
        add(PUT, 16'h8, 64'h88, INS,  64'h0,  INS,  64'h0,  3'd4, 1'b1);
        add(PUT, 16'hA, 64'hAA, EVI,  64'h11, FUL,  64'h0,  3'd4, 1'b1);
        add(GET, 16'h1, 64'h0,  MISS, 64'h0,  HIT,  64'h11, 3'd4, 1'b1);
        add(GET, 16'h7, 64'h0,  HIT,  64'h77, HIT,  64'h77, 3'd4, 1'b1);
        add(CLR, 16'h0, 64'h0,  CLRD, 64'h0,  CLRD, 64'h0,  3'd0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",   req_ready_a,   1'b1);
        check("rst_resp_valid",  resp_valid_a,  1'b0);
        check("rst_resp_status", resp_status_a, 3'd0);
        check("rst_resp_value",  resp_value_a,  64'h0);
        check("rst_occupancy",   occ_a,         3'd0);
        check("rst_full",        full_a,        1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_range(0, 1);
        check("resp_latency", lat, 2);
        apply_range(1, 22);
        check("slot1_key_after_reinsert", u_a.g_entry[1].u_entry.key_q, 16'h7);
        apply_range(22, vecs.size());

        // Backpressure: response held while a new request waits unconsumed
        req_valid = 1'b1; req_op = PUT; req_key = 16'h1; req_value = 64'h5; resp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            check("hold_resp_valid",  resp_valid_a,  1'b1);
            check("hold_resp_status", resp_status_a, INS);
            check("hold_req_ready",   req_ready_a,   1'b0);
            check("hold_occupancy",   occ_a,         3'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid_a, 1'b0);
        check("midrst_occupancy",  occ_a,        3'd0);
        check("midrst_req_ready",  req_ready_a,  1'b1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(GET, 16'h1, 64'h0);
        check("post_rst_get_status", cap_st_a, MISS);
        check("post_rst_get_value",  cap_rv_a, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
